// File: rtl/gcd_pkg.sv
// gcd_pkg: definitions shared by the GCD dispatcher slice.
//   WIDTH_DEF   - default operand/result width
//   DEPTH_DEF   - default operand FIFO depth (power of two, >= 2)
//   TIMEOUT_DEF - default number of cycles to wait for the engine
//   state_t     - dispatcher FSM state encoding
package gcd_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 4096;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;  // waiting for a queued pair
  localparam state_t S_ISSUE = 2'd1;  // start pulse to the engine
  localparam state_t S_WAIT  = 2'd2;  // waiting for engine done / timeout
  localparam state_t S_HOLD  = 2'd3;  // result presented to the consumer

endpackage

// File: rtl/gcd_dispatch_if.sv
// gcd_dispatch_if: all handshake signals of the GCD dispatcher.
//   in_valid/in_a/in_b/in_ready      - operand pair stream into the FIFO
//   gcd_start/gcd_a/gcd_b            - request to the GCD engine
//   gcd_answer/gcd_done              - response from the GCD engine
//   out_valid/out_answer/out_ready   - result stream to the consumer
//   timeout_err                      - sticky engine timeout flag
// Modports: slave = the dispatcher, master = its environment
// (producer, consumer and engine together).
interface gcd_dispatch_if
  import gcd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             in_valid;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_ready;

  logic             gcd_start;
  logic [WIDTH-1:0] gcd_a;
  logic [WIDTH-1:0] gcd_b;
  logic [WIDTH-1:0] gcd_answer;
  logic             gcd_done;

  logic             out_valid;
  logic [WIDTH-1:0] out_answer;
  logic             out_ready;

  logic             timeout_err;

  modport slave (
    input  in_valid, in_a, in_b, gcd_answer, gcd_done, out_ready,
    output in_ready, gcd_start, gcd_a, gcd_b, out_valid, out_answer, timeout_err
  );

  modport master (
    output in_valid, in_a, in_b, gcd_answer, gcd_done, out_ready,
    input  in_ready, gcd_start, gcd_a, gcd_b, out_valid, out_answer, timeout_err
  );

endinterface

// File: rtl/gcd_fifo.sv
// gcd_fifo: synchronous FIFO holding operand pairs for the dispatcher.
//   clk, reset - clock, synchronous active-high reset (empties the FIFO)
//   push       - write data_in when not full
//   pop        - drop the head entry when not empty
//   data_in    - entry to write
//   data_out   - current head entry (valid when !empty)
//   full/empty - occupancy flags
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers
// differing only in the wrap bit mean full.
module gcd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign data_out = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; entries are only ever read
  // between a push and its pop, so the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data_in;
  end

endmodule

// File: rtl/gcd_dispatch.sv
// gcd_dispatch: queues operand pairs and feeds them one at a time to an
// external GCD engine, returning results in arrival order.
//   clk   - single clock, all logic on posedge
//   reset - synchronous active-high reset
//   bus   - gcd_dispatch_if.slave: input pair stream, engine request and
//           response, result stream and sticky timeout_err
// Pairs with a zero operand bypass the engine (result is the other operand).
// The engine gets TIMEOUT cycles to raise done; a timeout yields result 0
// and sets timeout_err until the next reset.
module gcd_dispatch
  import gcd_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  gcd_dispatch_if.slave bus
);

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t           state;
  logic [CW-1:0]    wait_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic [2*WIDTH-1:0] head;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;

  assign {head_a, head_b} = head;
  assign pop              = (state == S_IDLE) && !fifo_empty;

  assign bus.in_ready  = !fifo_full;
  assign bus.gcd_start = (state == S_ISSUE);
  assign bus.out_valid = (state == S_HOLD);

  gcd_fifo #(
    .WIDTH (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (bus.in_valid),
    .pop      (pop),
    .data_in  ({bus.in_a, bus.in_b}),
    .data_out (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      wait_cnt        <= '0;
      bus.gcd_a       <= '0;
      bus.gcd_b       <= '0;
      bus.out_answer  <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            bus.gcd_a <= head_a;
            bus.gcd_b <= head_b;
            if (head_a != '0 && head_b != '0) begin
              state <= S_ISSUE;
            end else begin
              // a==0 -> b, b==0 -> a; both zero falls out as b == 0
              bus.out_answer <= (head_a == '0) ? head_b : head_a;
              state          <= S_HOLD;
            end
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // wait_cnt == 0 is the first WAIT cycle: done may still be the
          // previous operation's level, so it is not trusted yet.
          if (wait_cnt != '0 && bus.gcd_done) begin
            bus.out_answer <= bus.gcd_answer;
            state          <= S_HOLD;
          end else if (wait_cnt == TO_LAST) begin
            bus.timeout_err <= 1'b1;
            bus.out_answer  <= '0;
            state           <= S_HOLD;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_dispatch.sv
// tb_gcd_dispatch: self-checking bench for gcd_dispatch with a behavioural
// GCD engine. Expected results are queued when a pair is accepted and
// compared when the dispatcher hands a result to the consumer.
module tb_gcd_dispatch;
  import gcd_pkg::*;

  localparam int            W      = 16;
  localparam int            D      = 4;
  localparam int            TO     = 16;
  localparam logic [W-1:0]  HANG_A = 16'hDEAD;  // engine never answers this a

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  gcd_dispatch_if #(.WIDTH(W)) bus ();

  gcd_dispatch #(
    .WIDTH   (W),
    .DEPTH   (D),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int           n_tests      = 0;
  int           n_fail       = 0;
  logic [W-1:0] exp_q [$];
  int           cyc          = 0;
  int           start_count  = 0;
  int           result_count = 0;
  int           start_cyc    = 0;
  int           acc_cyc      = 0;
  int           valid_cyc    = 0;
  bit           prev_valid   = 1'b0;

  int           lat   = 1;
  bit           stuck = 1'b0;
  logic [W-1:0] eng_a, eng_b;
  int           eng_cnt;
  bit           sdelay;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x = a;
    logic [W-1:0] y = b;
    logic [W-1:0] t;
    for (int i = 0; i < 64 && y != '0; i++) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Behavioural engine: done pulse `lat` cycles after start, or done held
  // high with a stale answer for one cycle when `stuck` is set.
  always @(posedge clk) begin
    if (reset) begin
      bus.gcd_done   <= 1'b0;
      bus.gcd_answer <= '0;
      eng_cnt        <= 0;
      sdelay         <= 1'b0;
    end else if (bus.gcd_start) begin
      eng_a          <= bus.gcd_a;
      eng_b          <= bus.gcd_b;
      eng_cnt        <= (bus.gcd_a == HANG_A) ? 0 : lat;
      bus.gcd_answer <= 16'hBEEF;
      sdelay         <= 1'b1;
      bus.gcd_done   <= stuck;
    end else if (stuck) begin
      bus.gcd_done <= 1'b1;
      if (sdelay) begin
        bus.gcd_answer <= gcd_ref(eng_a, eng_b);
        sdelay         <= 1'b0;
      end
    end else if (eng_cnt == 1) begin
      bus.gcd_done   <= 1'b1;
      bus.gcd_answer <= gcd_ref(eng_a, eng_b);
      eng_cnt        <= 0;
    end else begin
      bus.gcd_done <= 1'b0;
      if (eng_cnt > 1) eng_cnt <= eng_cnt - 1;
    end
  end

  // Monitor / scoreboard, sampling on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (bus.gcd_start) begin
        start_count++;
        start_cyc = cyc;
      end
      if (bus.in_valid && bus.in_ready) acc_cyc = cyc;
      if (bus.out_valid && !prev_valid) valid_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        result_count++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got %0d, expected no result", bus.out_answer);
        end else begin
          check("result", 32'(bus.out_answer), 32'(exp_q.pop_front()));
        end
      end
    end
    prev_valid = bus.out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one pair for one cycle; called at posedge+1, returns at posedge+1.
  task automatic try_send(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, output bit ok);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    @(negedge clk);
    ok = bus.in_ready;
    tick();
    bus.in_valid = 1'b0;
    if (ok) exp_q.push_back(exp);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) try_send(a, b, exp, ok);
    check("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !bus.out_valid) done = 1'b1;
    end
    check("drain_outstanding", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
  endtask

  // sel 0: gcd_start, sel 1: out_valid. Returns at negedge+1.
  task automatic wait_sig(input string name, input int sel, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = (sel == 0) ? bus.gcd_start : bus.out_valid;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  vec_t vecs [10];
  vec_t fill [5];

  initial begin
    int s0;
    int r0;
    int n_ok;
    bit ok;

    vecs = '{
      '{16'd21,    16'd15,    16'd3},
      '{16'd0,     16'd9,     16'd9},
      '{16'd12,    16'd0,     16'd12},
      '{16'd0,     16'd0,     16'd0},
      '{16'd48,    16'd36,    16'd12},
      '{16'd17,    16'd5,     16'd1},
      '{16'd100,   16'd75,    16'd25},
      '{16'd8,     16'd8,     16'd8},
      '{16'd65535, 16'd255,   16'd255},
      '{16'd1,     16'd65535, 16'd1}
    };
    fill = '{
      '{16'd48,  16'd36, 16'd12},
      '{16'd17,  16'd5,  16'd1},
      '{16'd100, 16'd75, 16'd25},
      '{16'd8,   16'd8,  16'd8},
      '{16'd30,  16'd20, 16'd10}
    };

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",    32'(bus.in_ready),    32'd1);
    check("rst_gcd_start",   32'(bus.gcd_start),   32'd0);
    check("rst_gcd_a",       32'(bus.gcd_a),       32'd0);
    check("rst_gcd_b",       32'(bus.gcd_b),       32'd0);
    check("rst_out_valid",   32'(bus.out_valid),   32'd0);
    check("rst_out_answer",  32'(bus.out_answer),  32'd0);
    check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Single engine operation: one start pulse, operands held
    bus.out_ready = 1'b1;
    s0 = start_count;
    send(16'd21, 16'd15, 16'd3);
    wait_sig("start_seen", 0, 20);
    check("issue_gcd_a", 32'(bus.gcd_a), 32'd21);
    check("issue_gcd_b", 32'(bus.gcd_b), 32'd15);
    wait_sig("valid_seen", 1, 20);
    check("held_gcd_a", 32'(bus.gcd_a), 32'd21);
    check("held_gcd_b", 32'(bus.gcd_b), 32'd15);
    check("start_pulses", 32'(start_count - s0), 32'd1);
    check("engine_latency", 32'(valid_cyc - start_cyc), 32'd3);
    wait_drain(50);

    // Bypass pairs: no engine start, result one cycle after pop
    s0 = start_count;
    send(16'd0, 16'd9, 16'd9);
    wait_drain(50);
    check("bypass_latency", 32'(valid_cyc - acc_cyc), 32'd2);
    send(16'd12, 16'd0, 16'd12);
    send(16'd0, 16'd0, 16'd0);
    wait_drain(50);
    check("bypass_no_start", 32'(start_count - s0), 32'd0);

    // Table of mixed pairs, back to back
    lat = $urandom_range(1, 6);
    s0  = start_count;
    for (int i = 0; i < 10; i++) send(vecs[i].a, vecs[i].b, vecs[i].exp);
    wait_drain(400);
    check("table_starts", 32'(start_count - s0), 32'd7);

    // Full FIFO: park a result in HOLD, then 4 fill the FIFO, 5th refused
    lat = 1;
    bus.out_ready = 1'b0;
    send(16'd0, 16'd7, 16'd7);
    wait_sig("parked_valid", 1, 20);
    tick();
    n_ok = 0;
    ok   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      try_send(fill[i].a, fill[i].b, fill[i].exp, ok);
      n_ok += int'(ok);
    end
    check("full_accepted", 32'(n_ok), 32'd4);
    check("fifth_refused", 32'(ok), 32'd0);
    @(negedge clk);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.out_ready = 1'b1;
    wait_drain(200);

    // Done stuck high: first WAIT cycle must not capture the stale answer
    stuck = 1'b1;
    s0 = start_count;
    send(16'd21, 16'd15, 16'd3);
    wait_drain(50);
    check("stuck_latency", 32'(valid_cyc - start_cyc), 32'd3);
    check("stuck_starts", 32'(start_count - s0), 32'd1);
    stuck = 1'b0;
    tick();

    // Engine timeout, next queued pair still served
    check("pre_timeout_err", 32'(bus.timeout_err), 32'd0);
    send(HANG_A, 16'd5, 16'd0);
    send(16'd48, 16'd36, 16'd12);
    wait_sig("timeout_valid", 1, 40);
    check("timeout_latency", 32'(valid_cyc - start_cyc), 32'd17);
    check("timeout_err_set", 32'(bus.timeout_err), 32'd1);
    tick();
    wait_drain(100);
    check("timeout_err_sticky", 32'(bus.timeout_err), 32'd1);

    // Reset in WAIT with two pairs queued: everything abandoned
    send(HANG_A, 16'd1, 16'd0);
    send(16'd12, 16'd8, 16'd4);
    send(16'd9, 16'd6, 16'd3);
    wait_sig("hang_start", 0, 20);
    repeat (3) @(negedge clk);
    tick();
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("wrst_out_valid",   32'(bus.out_valid),   32'd0);
    check("wrst_in_ready",    32'(bus.in_ready),    32'd1);
    check("wrst_timeout_err", 32'(bus.timeout_err), 32'd0);
    check("wrst_gcd_a",       32'(bus.gcd_a),       32'd0);
    r0 = result_count;
    s0 = start_count;
    repeat (60) @(negedge clk);
    check("wrst_no_result", 32'(result_count - r0), 32'd0);
    check("wrst_no_start",  32'(start_count - s0),  32'd0);
    tick();

    // Random pairs, some with zero operands
    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] a, b;
      lat = $urandom_range(1, 8);
      a = W'($urandom_range(0, 300));
      b = W'($urandom_range(0, 300));
      if (i % 5 == 0) a = '0;
      send(a, b, gcd_ref(a, b));
    end
    wait_drain(600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
